// File: rtl/bumpy_move_fsm.sv
// Frame-tick driven movement FSM for the bouncing 64x64 sprite: walking, falling, jumping, wall/top bounce and death.
// Define BUMPY_SCREEN_WRAP_EN to make the sprite wrap across the left/right screen edges instead of bouncing.
module bumpy_move_fsm #(
  parameter int INIT_X      = 300,
  parameter int INIT_Y      = 100,
  parameter int X_SPEED     = 4,
  parameter int FALL_SPEED  = 3,
  parameter int RISE_SPEED  = 3,
  parameter int JUMP_FRAMES = 20,
  parameter int LEFT_BOUND  = 0,
  parameter int RIGHT_BOUND = 576,
  parameter int TOP_BOUND   = 0,
  parameter int FLOOR_Y     = 416,
  parameter int DIE_FRAMES  = 60
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_startOfFrame,
  input  logic               i_startKey,
  input  logic               i_leftKey,
  input  logic               i_rightKey,
  input  logic               i_floorHit,
  input  logic               i_dieReq,
  output logic [3:0]         o_state,
  output logic signed [10:0] o_topLeftX,
  output logic signed [10:0] o_topLeftY
);

  localparam logic [3:0] Sreset             = 4'd0;
  localparam logic [3:0] Sidle              = 4'd1;
  localparam logic [3:0] Sleft              = 4'd2;
  localparam logic [3:0] Sright             = 4'd3;
  localparam logic [3:0] Sdown              = 4'd4;
  localparam logic [3:0] Sup                = 4'd5;
  localparam logic [3:0] Sdie               = 4'd6;
  localparam logic [3:0] Sbounce_from_left  = 4'd7;
  localparam logic [3:0] Sbounce_from_right = 4'd8;
  localparam logic [3:0] Sbounce_from_top   = 4'd9;

  localparam int JW = $clog2(JUMP_FRAMES + 1);
  localparam int DW = $clog2(DIE_FRAMES + 1);

  localparam logic signed [10:0] X_INIT    = 11'(INIT_X);
  localparam logic signed [10:0] Y_INIT    = 11'(INIT_Y);
  localparam logic signed [11:0] X_STEP    = 12'(X_SPEED);
  localparam logic signed [11:0] FALL_STEP = 12'(FALL_SPEED);
  localparam logic signed [11:0] RISE_STEP = 12'(RISE_SPEED);
  localparam logic signed [11:0] LEFT_LIM  = 12'(LEFT_BOUND);
  localparam logic signed [11:0] RIGHT_LIM = 12'(RIGHT_BOUND);
  localparam logic signed [11:0] TOP_LIM   = 12'(TOP_BOUND);
  localparam logic signed [11:0] FLOOR_LIM = 12'(FLOOR_Y);
  localparam logic [JW-1:0]      JUMP_LOAD = JW'(JUMP_FRAMES);
  localparam logic [DW-1:0]      DIE_LAST  = DW'(DIE_FRAMES - 1);

  logic [3:0]         r_state;
  logic signed [10:0] r_x;
  logic signed [10:0] r_y;
  logic [JW-1:0]      r_jumpCnt;
  logic [DW-1:0]      r_dieCnt;

  logic [3:0]         w_stateNext;
  logic signed [10:0] w_xNext;
  logic signed [10:0] w_yNext;
  logic [JW-1:0]      w_jumpNext;
  logic [DW-1:0]      w_dieNext;

  logic signed [11:0] w_x12;
  logic signed [11:0] w_y12;
  logic signed [11:0] w_dx;
  logic signed [11:0] w_nextX;
  logic signed [11:0] w_fallY;
  logic signed [11:0] w_riseY;
  logic [3:0]         w_keyState;
  logic signed [10:0] w_moveX;
  logic               w_wallHit;
  logic [3:0]         w_wallState;
  logic [3:0]         w_vState;
  logic signed [10:0] w_vY;
  logic [JW-1:0]      w_vJump;

  assign w_x12   = {r_x[10], r_x};
  assign w_y12   = {r_y[10], r_y};
  assign w_nextX = w_x12 + w_dx;
  assign w_fallY = w_y12 + FALL_STEP;
  assign w_riseY = w_y12 - RISE_STEP;

  // Exactly one key held moves the sprite; both or neither cancel out.
  always_comb begin
    w_dx       = '0;
    w_keyState = Sdown;
    if (i_leftKey && !i_rightKey) begin
      w_dx       = -X_STEP;
      w_keyState = Sleft;
    end else if (i_rightKey && !i_leftKey) begin
      w_dx       = X_STEP;
      w_keyState = Sright;
    end
  end

  always_comb begin
    w_moveX     = w_nextX[10:0];
    w_wallHit   = 1'b0;
    w_wallState = Sbounce_from_left;
`ifdef BUMPY_SCREEN_WRAP_EN
    if (w_nextX < LEFT_LIM) begin
      w_moveX = RIGHT_LIM[10:0];
    end else if (w_nextX > RIGHT_LIM) begin
      w_moveX = LEFT_LIM[10:0];
    end
`else
    if (w_nextX < LEFT_LIM) begin
      w_moveX     = LEFT_LIM[10:0];
      w_wallHit   = 1'b1;
      w_wallState = Sbounce_from_left;
    end else if (w_nextX > RIGHT_LIM) begin
      w_moveX     = RIGHT_LIM[10:0];
      w_wallHit   = 1'b1;
      w_wallState = Sbounce_from_right;
    end
`endif
  end

  // Vertical step: rising burns one jump frame per tick, falling lands on the floor or a brick.
  always_comb begin
    w_vState = w_keyState;
    w_vY     = r_y;
    w_vJump  = r_jumpCnt;
    if (r_state == Sup) begin
      if (w_riseY <= TOP_LIM) begin
        w_vY     = TOP_LIM[10:0];
        w_vJump  = '0;
        w_vState = Sbounce_from_top;
      end else begin
        w_vY = w_riseY[10:0];
        if (r_jumpCnt > JW'(1)) begin
          w_vJump  = r_jumpCnt - JW'(1);
          w_vState = Sup;
        end else begin
          w_vJump  = '0;
          w_vState = w_keyState;
        end
      end
    end else if (w_fallY >= FLOOR_LIM) begin
      w_vY     = FLOOR_LIM[10:0];
      w_vJump  = JUMP_LOAD;
      w_vState = Sup;
    end else if (i_floorHit) begin
      w_vJump  = JUMP_LOAD;
      w_vState = Sup;
    end else begin
      w_vY = w_fallY[10:0];
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_xNext     = r_x;
    w_yNext     = r_y;
    w_jumpNext  = r_jumpCnt;
    w_dieNext   = r_dieCnt;
    case (r_state)
      Sidle: begin
        if (i_startOfFrame && i_startKey) begin
          w_stateNext = Sdown;
        end
      end
      Sleft, Sright, Sdown, Sup: begin
        if (i_startOfFrame) begin
          if (i_dieReq) begin
            w_stateNext = Sdie;
            w_dieNext   = '0;
          end else if (w_wallHit) begin
            w_stateNext = w_wallState;
            w_xNext     = w_moveX;
          end else begin
            w_stateNext = w_vState;
            w_xNext     = w_moveX;
            w_yNext     = w_vY;
            w_jumpNext  = w_vJump;
          end
        end
      end
      Sbounce_from_left, Sbounce_from_right, Sbounce_from_top: begin
        if (i_startOfFrame) begin
          if (i_dieReq) begin
            w_stateNext = Sdie;
            w_dieNext   = '0;
          end else if (r_state != Sbounce_from_top && r_jumpCnt != '0) begin
            w_stateNext = Sup;
          end else begin
            w_stateNext = Sdown;
          end
        end
      end
      Sdie: begin
        if (i_startOfFrame) begin
          if (r_dieCnt == DIE_LAST) begin
            w_stateNext = Sreset;
            w_xNext     = X_INIT;
            w_yNext     = Y_INIT;
            w_jumpNext  = '0;
            w_dieNext   = '0;
          end else begin
            w_dieNext = r_dieCnt + DW'(1);
          end
        end
      end
      // Sreset and unused encodings restart cleanly on the next clock, tick or not.
      default: begin
        w_stateNext = (r_state == Sreset) ? Sidle : Sreset;
        w_xNext     = X_INIT;
        w_yNext     = Y_INIT;
        w_jumpNext  = '0;
        w_dieNext   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= Sreset;
      r_x       <= X_INIT;
      r_y       <= Y_INIT;
      r_jumpCnt <= '0;
      r_dieCnt  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_x       <= w_xNext;
      r_y       <= w_yNext;
      r_jumpCnt <= w_jumpNext;
      r_dieCnt  <= w_dieNext;
    end
  end

  assign o_state    = r_state;
  assign o_topLeftX = r_x;
  assign o_topLeftY = r_y;

endmodule
